// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-RAM arbiter: FSM states, write-size codes,
// and the byte count for each write code.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] WR_RD = 2'b00;
    localparam logic [1:0] WR_B1 = 2'b01;
    localparam logic [1:0] WR_B4 = 2'b10;
    localparam logic [1:0] WR_B8 = 2'b11;

    function automatic logic [3:0] nbytes(input logic [1:0] wr);
        case (wr)
            WR_B1:   nbytes = 4'd1;
            WR_B4:   nbytes = 4'd4;
            WR_B8:   nbytes = 4'd8;
            default: nbytes = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright; on a tie the
// requester that did not hold the last grant wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic gnt
);

    always_comb begin
        valid = req0 | req1;
        gnt   = 1'b0;
        if (req0 && req1)
            gnt = ~last;
        else if (req1)
            gnt = 1'b1;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the byte-write / 64-bit-read data RAM between the CPU port and the host port.
// One grant at a time; reads take one cycle, writes go out one byte per cycle.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic [1:0]    cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          hst_req,
    input  logic [1:0]    hst_wr,
    input  logic [AW-1:0] hst_addr,
    input  logic [DW-1:0] hst_wdata,
    output logic          hst_ack,
    output logic [DW-1:0] hst_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wbyte,
    input  logic [DW-1:0] ram_q,
    output logic          busy,
    output logic          owner
);

    state_e        state, state_nxt;
    logic          gnt_valid, gnt;
    logic [1:0]    wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [2:0]    cnt_q;
    logic [2:0]    last_idx;
    logic [1:0]    sel_wr;

    rr_arb2 u_arb (
        .req0  (cpu_req),
        .req1  (hst_req),
        .last  (owner),
        .valid (gnt_valid),
        .gnt   (gnt)
    );

    assign sel_wr   = gnt ? hst_wr : cpu_wr;
    assign last_idx = 3'(nbytes(wr_q) - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = (sel_wr == WR_RD) ? READ : WRITE;
            READ:    state_nxt = DONE;
            WRITE:   if (cnt_q == last_idx) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        cpu_ack   = (state == DONE) && !owner;
        hst_ack   = (state == DONE) && owner;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wbyte = 8'h00;
        case (state)
            READ: ram_addr = addr_q;
            WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = addr_q + AW'(cnt_q);
                ram_wbyte = wdata_q[{cnt_q, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    // Owner resets to host so the first tie after reset goes to the CPU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b1;
            wr_q      <= WR_RD;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            cpu_rdata <= '0;
            hst_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_valid) begin
                    owner   <= gnt;
                    wr_q    <= sel_wr;
                    addr_q  <= gnt ? hst_addr : cpu_addr;
                    wdata_q <= gnt ? hst_wdata : cpu_wdata;
                    cnt_q   <= '0;
                end
                READ: begin
                    if (owner) hst_rdata <= ram_q;
                    else       cpu_rdata <= ram_q;
                end
                WRITE:   cnt_q <= cnt_q + 3'd1;
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-array RAM model behind the RAM port.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, hst_req = 1'b0;
    logic [1:0]  cpu_wr = 2'b00, hst_wr = 2'b00;
    logic [15:0] cpu_addr = '0, hst_addr = '0;
    logic [63:0] cpu_wdata = '0, hst_wdata = '0;
    logic        cpu_ack, hst_ack;
    logic [63:0] cpu_rdata, hst_rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wbyte;
    logic [63:0] ram_q;
    logic        busy, owner;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    ram_arbiter #(.AW(16), .DW(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .hst_req(hst_req), .hst_wr(hst_wr), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
        .hst_ack(hst_ack), .hst_rdata(hst_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wbyte(ram_wbyte), .ram_q(ram_q),
        .busy(busy), .owner(owner)
    );

    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wbyte;

    always @* begin
        ram_q = '0;
        for (int i = 0; i < 8; i++) ram_q[8*i +: 8] = mem[ram_addr + 16'(i)];
    end

    task automatic test_reset;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
        vectors++; if (owner !== 1'b1) begin miscompares++; $display("FAIL reset_owner got %0b want 1", owner); end
        vectors++; if ({cpu_ack, hst_ack, ram_we} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes got %b want 000", {cpu_ack, hst_ack, ram_we}); end
        vectors++; if (ram_addr !== 16'h0000 || ram_wbyte !== 8'h00) begin miscompares++; $display("FAIL reset_ramport got %h/%h want 0000/00", ram_addr, ram_wbyte); end
        vectors++; if (cpu_rdata !== 64'h0 || hst_rdata !== 64'h0) begin miscompares++; $display("FAIL reset_rdata got %h/%h want 0", cpu_rdata, hst_rdata); end
    endtask

    task automatic test_cpu_read;
        logic [63:0] pat;
        pat = 64'h0123456789ABCDEF;
        for (int i = 0; i < 8; i++) mem[16'h0100 + 16'(i)] = pat[8*i +: 8];
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr = 2'b00; cpu_addr = 16'h0100;
        @(posedge clk); @(negedge clk);
        vectors++; if (ram_addr !== 16'h0100 || ram_we !== 1'b0 || cpu_ack !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL rd_cycle addr=%h we=%b ack=%b busy=%b want 0100/0/0/1", ram_addr, ram_we, cpu_ack, busy); end
        @(posedge clk); @(negedge clk);
        vectors++; if (cpu_ack !== 1'b1 || hst_ack !== 1'b0) begin miscompares++; $display("FAIL rd_ack cpu=%b hst=%b want 1/0", cpu_ack, hst_ack); end
        vectors++; if (cpu_rdata !== pat) begin miscompares++; $display("FAIL rd_data got %h want %h", cpu_rdata, pat); end
        vectors++; if (owner !== 1'b0) begin miscompares++; $display("FAIL rd_owner got %b want 0", owner); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        vectors++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rd_ack_width ack=%b busy=%b want 0/0", cpu_ack, busy); end
    endtask

    task automatic test_host_write8;
        logic [63:0] wd;
        wd = 64'h1122334455667788;
        @(posedge clk); #1;
        hst_req = 1'b1; hst_wr = 2'b11; hst_addr = 16'h0010; hst_wdata = wd;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++; if (ram_we !== 1'b1 || ram_addr !== 16'h0010 + 16'(i) || ram_wbyte !== wd[8*i +: 8] || hst_ack !== 1'b0) begin
                miscompares++; $display("FAIL w8_byte%0d we=%b addr=%h byte=%h ack=%b want 1/%h/%h/0",
                    i, ram_we, ram_addr, ram_wbyte, hst_ack, 16'h0010 + 16'(i), wd[8*i +: 8]); end
            @(posedge clk);
        end
        @(negedge clk);
        vectors++; if (hst_ack !== 1'b1 || cpu_ack !== 1'b0 || ram_we !== 1'b0) begin
            miscompares++; $display("FAIL w8_ack hst=%b cpu=%b we=%b want 1/0/0", hst_ack, cpu_ack, ram_we); end
        @(posedge clk); #1;
        hst_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++; if (mem[16'h0010 + 16'(i)] !== wd[8*i +: 8]) begin
                miscompares++; $display("FAIL w8_mem%0d got %h want %h", i, mem[16'h0010 + 16'(i)], wd[8*i +: 8]); end
        end
        vectors++; if (cpu_rdata !== 64'h0123456789ABCDEF) begin miscompares++; $display("FAIL rdata_hold got %h want 0123456789abcdef", cpu_rdata); end
    endtask

    task automatic test_wrap_write4;
        logic [15:0] exp_a [4];
        logic [7:0]  exp_b [4];
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr = 2'b10; cpu_addr = 16'hFFFE; cpu_wdata = 64'hCAFE_F00D_DEAD_BEEF;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if (ram_we !== 1'b1 || ram_addr !== exp_a[i] || ram_wbyte !== exp_b[i]) begin
                miscompares++; $display("FAIL wrap_byte%0d we=%b addr=%h byte=%h want 1/%h/%h", i, ram_we, ram_addr, ram_wbyte, exp_a[i], exp_b[i]); end
            @(posedge clk);
        end
        @(negedge clk);
        vectors++; if (cpu_ack !== 1'b1) begin miscompares++; $display("FAIL wrap_ack got %b want 1", cpu_ack); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        vectors++; if (mem[16'h0002] !== 8'h00) begin miscompares++; $display("FAIL wrap_overrun got %h want 00", mem[16'h0002]); end
    endtask

    task automatic test_round_robin;
        bit got_host;
        bit seen;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_wr = 2'b00; cpu_addr = 16'h0100;
        hst_req = 1'b1; hst_wr = 2'b01; hst_addr = 16'h0020; hst_wdata = 64'h00000000000000AB;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (cpu_ack || hst_ack) seen = 1'b1;
            end
            got_host = hst_ack;
            vectors++; if (!seen) begin miscompares++; $display("FAIL rr_timeout grant%0d got none want %0d", k, k % 2); end
            else if (got_host !== 1'(k % 2) || (cpu_ack && hst_ack)) begin
                miscompares++; $display("FAIL rr_order grant%0d cpu_ack=%b hst_ack=%b want host=%0d", k, cpu_ack, hst_ack, k % 2); end
            @(posedge clk); #1;
            if (got_host) hst_req = 1'b0; else cpu_req = 1'b0;
            @(posedge clk); #1;
            if (k < 3) begin
                if (got_host) hst_req = 1'b1; else cpu_req = 1'b1;
            end else begin
                cpu_req = 1'b0; hst_req = 1'b0;
            end
        end
        repeat (12) @(posedge clk);
        #1;
        vectors++; if (mem[16'h0020] !== 8'hAB || cpu_rdata !== 64'h0123456789ABCDEF) begin
            miscompares++; $display("FAIL rr_data mem=%h rdata=%h want ab/0123456789abcdef", mem[16'h0020], cpu_rdata); end
    endtask

    task automatic test_tie_after_cpu;
        cpu_req = 1'b1; cpu_wr = 2'b00; cpu_addr = 16'h0100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (cpu_ack !== 1'b1) begin miscompares++; $display("FAIL tie_pre_ack got %b want 1", cpu_ack); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b1; hst_req = 1'b1; hst_wr = 2'b00; hst_addr = 16'h0010;
        @(posedge clk); @(negedge clk);
        vectors++; if (owner !== 1'b1 || ram_addr !== 16'h0010) begin
            miscompares++; $display("FAIL tie_host owner=%b addr=%h want 1/0010", owner, ram_addr); end
        @(posedge clk); @(negedge clk);
        vectors++; if (hst_ack !== 1'b1 || hst_rdata !== 64'h1122334455667788) begin
            miscompares++; $display("FAIL tie_host_rd ack=%b data=%h want 1/1122334455667788", hst_ack, hst_rdata); end
        @(posedge clk); #1;
        hst_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (cpu_ack !== 1'b1) begin miscompares++; $display("FAIL tie_cpu_next got %b want 1", cpu_ack); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        for (int i = 0; i < 8; i++) mem[16'h0200 + 16'(i)] = 8'h5A;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr = 2'b11; cpu_addr = 16'h0200; cpu_wdata = 64'h0807060504030201;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (ram_we !== 1'b1 || ram_addr !== 16'h0203) begin miscompares++; $display("FAIL mid_pre we=%b addr=%h want 1/0203", ram_we, ram_addr); end
        rst_n = 1'b0;
        #1;
        vectors++; if (ram_we !== 1'b0 || busy !== 1'b0 || cpu_ack !== 1'b0) begin
            miscompares++; $display("FAIL mid_async we=%b busy=%b ack=%b want 0/0/0", ram_we, busy, cpu_ack); end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || cpu_ack !== 1'b0 || hst_ack !== 1'b0 || owner !== 1'b1) begin
            miscompares++; $display("FAIL mid_after busy=%b acks=%b%b owner=%b want 0/00/1", busy, cpu_ack, hst_ack, owner); end
        vectors++; if (cpu_rdata !== 64'h0 || hst_rdata !== 64'h0) begin
            miscompares++; $display("FAIL mid_rdata got %h/%h want 0", cpu_rdata, hst_rdata); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (mem[16'h0200 + 16'(i)] !== ((i < 3) ? 8'(i + 1) : 8'h5A)) begin
                miscompares++; $display("FAIL mid_mem%0d got %h want %h", i, mem[16'h0200 + 16'(i)], (i < 3) ? 8'(i + 1) : 8'h5A); end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        #12;
        test_reset;
        rst_n = 1'b1;
        test_cpu_read;
        test_host_write8;
        test_wrap_write4;
        test_round_robin;
        test_tie_after_cpu;
        test_reset_mid_write;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
